// File: rtl/dmem_access_unit.sv
// Memory-stage load/store responder: turns M-stage accesses into single wait-stated bus
// transfers, stalling the pipeline until the transfer completes or times out.
module dmem_access_unit #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYC - 1);

    logic [1:0]  state;
    logic [9:0]  waitCount;
    logic [2:0]  sizeReg;
    logic [1:0]  offsetReg;
    logic        access;
    logic        illegal;
    logic [3:0]  storeStrb;
    logic [31:0] storeData;
    logic [31:0] laneWord;
    logic [31:0] loadValue;

    assign access = MemReadM | MemWriteM;

    // Alignment and funct3 legality; a simultaneous read+write is judged as a store.
    always_comb begin
        illegal = 1'b0;
        case (funct3M)
            3'b000, 3'b100: illegal = 1'b0;
            3'b001, 3'b101: illegal = ALUResultM[0];
            3'b010:         illegal = (ALUResultM[1:0] != 2'b00);
            default:        illegal = 1'b1;
        endcase
        if (MemWriteM && funct3M[2])
            illegal = 1'b1;
    end

    always_comb begin
        storeStrb = 4'b1111;
        storeData = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                storeStrb = 4'b0001 << ALUResultM[1:0];
                storeData = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                storeStrb = ALUResultM[1] ? 4'b1100 : 4'b0011;
                storeData = {2{WriteDataM[15:0]}};
            end
            default: begin
                storeStrb = 4'b1111;
                storeData = WriteDataM;
            end
        endcase
    end

    assign laneWord = bus_rdata >> {offsetReg, 3'b000};

    always_comb begin
        loadValue = laneWord;
        case (sizeReg)
            3'b000:  loadValue = {{24{laneWord[7]}}, laneWord[7:0]};
            3'b100:  loadValue = {24'h0, laneWord[7:0]};
            3'b001:  loadValue = {{16{laneWord[15]}}, laneWord[15:0]};
            3'b101:  loadValue = {16'h0, laneWord[15:0]};
            default: loadValue = laneWord;
        endcase
    end

    // Stall is raised in the same cycle a legal access is seen so M holds immediately.
    assign StallM    = reset & (((state == IDLE) & access & ~illegal) | (state == BUSY));
    assign MisalignM = reset & (state == IDLE) & access & illegal;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            waitCount <= '0;
            sizeReg   <= '0;
            offsetReg <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wstrb <= '0;
            bus_wdata <= '0;
            ReadDataM <= '0;
            BusErrM   <= 1'b0;
        end else begin
            BusErrM <= 1'b0;
            case (state)
                IDLE: begin
                    waitCount <= '0;
                    if (access && !illegal) begin
                        bus_req   <= 1'b1;
                        bus_we    <= MemWriteM;
                        bus_addr  <= {ALUResultM[31:2], 2'b00};
                        bus_wstrb <= MemWriteM ? storeStrb : 4'b0000;
                        bus_wdata <= MemWriteM ? storeData : 32'h0;
                        sizeReg   <= funct3M;
                        offsetReg <= ALUResultM[1:0];
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack arriving on the final allowed cycle still completes normally.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we)
                            ReadDataM <= loadValue;
                        state <= RESP;
                    end else if (waitCount == TIMEOUT_LAST) begin
                        bus_req   <= 1'b0;
                        ReadDataM <= '0;
                        BusErrM   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        waitCount <= waitCount + 10'd1;
                    end
                end
                RESP: begin
                    waitCount <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized self-checking bench for dmem_access_unit; the bench plays the bus slave and
// predicts strobes, lane data and load results arithmetically from the access size and offset.
module tb_dmem_access_unit;

    localparam int TO = 8;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        MisalignM;
    logic        BusErrM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int checks = 0;
    int passes = 0;
    logic [31:0] expRead;

    dmem_access_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .StallM(StallM), .ReadDataM(ReadDataM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sizeBytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit modelLegal(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        bit known;
        known = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!known) return 0;
        if (wr && f3 >= 3'd4) return 0;
        return (addr % sizeBytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] modelStrb(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        n = sizeBytes(f3);
        return 4'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = sizeBytes(f3);
        r = '0;
        for (int lane = 0; lane < 4; lane++)
            r[lane*8 +: 8] = wd[(lane % n)*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        longint value;
        longint range;
        int n;
        n = sizeBytes(f3);
        range = longint'(1) << (8 * n);
        value = longint'(rdata >> (8 * (addr % 4))) % range;
        if (f3 < 3'd2 && value >= range / 2)
            value = value - range;
        return 32'(value);
    endfunction

    task automatic clearInputs();
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        funct3M   = 3'd0;
        ALUResultM = '0;
        WriteDataM = '0;
    endtask

    task automatic runAccess(input logic wr, input logic rd, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int waits, input string tag);
        bit legal;
        legal = modelLegal(wr, f3, addr);
        @(posedge clk); #1;
        MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
        bus_ack = 1'b0;
        #1;
        if (!(wr | rd)) begin
            checks++;
            if (StallM !== 1'b0 || MisalignM !== 1'b0)
                $display("[TB] FAIL %s idle: StallM=%b MisalignM=%b, want 0 0", tag, StallM, MisalignM);
            else passes++;
            clearInputs();
            return;
        end
        if (!legal) begin
            checks++;
            if (MisalignM !== 1'b1 || StallM !== 1'b0)
                $display("[TB] FAIL %s misalign: MisalignM=%b StallM=%b, want 1 0", tag, MisalignM, StallM);
            else passes++;
            clearInputs();
            @(posedge clk); #1;
            checks++;
            if (bus_req !== 1'b0 || MisalignM !== 1'b0)
                $display("[TB] FAIL %s after misalign: bus_req=%b MisalignM=%b, want 0 0", tag, bus_req, MisalignM);
            else passes++;
            return;
        end
        checks++;
        if (StallM !== 1'b1 || MisalignM !== 1'b0)
            $display("[TB] FAIL %s issue: StallM=%b MisalignM=%b, want 1 0", tag, StallM, MisalignM);
        else passes++;
        for (int i = 0; i <= waits; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                checks++;
                if (bus_addr !== {addr[31:2], 2'b00} || bus_we !== wr ||
                    bus_wstrb !== (wr ? modelStrb(f3, addr) : 4'b0000) ||
                    (wr && bus_wdata !== modelWdata(f3, wd)))
                    $display("[TB] FAIL %s request: addr=%h we=%b strb=%b wdata=%h, want %h %b %b %h", tag,
                             bus_addr, bus_we, bus_wstrb, bus_wdata, {addr[31:2], 2'b00}, wr,
                             wr ? modelStrb(f3, addr) : 4'b0000, modelWdata(f3, wd));
                else passes++;
            end
            checks++;
            if (StallM !== 1'b1 || bus_req !== 1'b1)
                $display("[TB] FAIL %s busy%0d: StallM=%b bus_req=%b, want 1 1", tag, i, StallM, bus_req);
            else passes++;
            if (i == waits) begin
                bus_ack = 1'b1;
                bus_rdata = rdata;
            end else begin
                bus_rdata = $urandom;
            end
        end
        if (!wr) expRead = modelLoad(f3, addr, rdata);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        checks++;
        if (StallM !== 1'b0 || bus_req !== 1'b0 || BusErrM !== 1'b0 || ReadDataM !== expRead)
            $display("[TB] FAIL %s resp: StallM=%b bus_req=%b BusErrM=%b ReadDataM=%h, want 0 0 0 %h",
                     tag, StallM, bus_req, BusErrM, ReadDataM, expRead);
        else passes++;
        clearInputs();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clearInputs();
        bus_ack = 1'b0;
        bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (StallM !== 1'b0 || MisalignM !== 1'b0 || BusErrM !== 1'b0 || bus_req !== 1'b0 ||
            bus_we !== 1'b0 || ReadDataM !== 32'h0 || bus_addr !== 32'h0 ||
            bus_wstrb !== 4'h0 || bus_wdata !== 32'h0)
            $display("[TB] FAIL reset: stall=%b mis=%b err=%b req=%b we=%b rd=%h addr=%h strb=%b wd=%h, want all 0",
                     StallM, MisalignM, BusErrM, bus_req, bus_we, ReadDataM, bus_addr, bus_wstrb, bus_wdata);
        else passes++;
        reset = 1'b1;
        expRead = '0;
    endtask

    task automatic test_directed();
        runAccess(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, "lw_wait1");
        runAccess(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, "lb_sign");
        runAccess(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, "lbu_zero");
        runAccess(1'b1, 1'b0, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 0, "sh_upper");
        runAccess(1'b1, 1'b1, 3'b000, 32'h205, 32'h000000A5, 32'h0, 2, "rw_as_store");
        runAccess(1'b0, 1'b1, 3'b101, 32'h106, 32'h0, 32'h9ABC1234, 0, "lhu_upper");
    endtask

    task automatic test_misalign();
        runAccess(1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 32'h0, 0, "lw_misalign");
        runAccess(1'b0, 1'b1, 3'b001, 32'h103, 32'h0, 32'h0, 0, "lh_misalign");
        runAccess(1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 0, "bad_funct3");
        runAccess(1'b1, 1'b0, 3'b100, 32'h100, 32'h0, 32'h0, 0, "store_unsigned");
    endtask

    task automatic test_timeout();
        @(posedge clk); #1;
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h40;
        for (int i = 0; i < TO; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus_req !== 1'b1 || StallM !== 1'b1 || BusErrM !== 1'b0)
                $display("[TB] FAIL timeout busy%0d: bus_req=%b StallM=%b BusErrM=%b, want 1 1 0",
                         i, bus_req, StallM, BusErrM);
            else passes++;
        end
        @(posedge clk); #1;
        expRead = '0;
        checks++;
        if (bus_req !== 1'b0 || BusErrM !== 1'b1 || StallM !== 1'b0 || ReadDataM !== 32'h0)
            $display("[TB] FAIL timeout resp: bus_req=%b BusErrM=%b StallM=%b ReadDataM=%h, want 0 1 0 0",
                     bus_req, BusErrM, StallM, ReadDataM);
        else passes++;
        clearInputs();
        @(posedge clk); #1;
        checks++;
        if (BusErrM !== 1'b0)
            $display("[TB] FAIL timeout pulse: BusErrM=%b, want 0", BusErrM);
        else passes++;
    endtask

    task automatic test_reset_midtransfer();
        @(posedge clk); #1;
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h80;
        @(posedge clk); #1;
        reset = 1'b0;
        clearInputs();
        @(posedge clk); #1;
        checks++;
        if (bus_req !== 1'b0 || StallM !== 1'b0)
            $display("[TB] FAIL reset_mid: bus_req=%b StallM=%b, want 0 0", bus_req, StallM);
        else passes++;
        reset = 1'b1;
        expRead = '0;
        bus_ack = 1'b1;
        bus_rdata = 32'h12345678;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus_req !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'h0)
            $display("[TB] FAIL stray_ack: bus_req=%b StallM=%b ReadDataM=%h, want 0 0 0",
                     bus_req, StallM, ReadDataM);
        else passes++;
    endtask

    task automatic test_random();
        logic [2:0] codes [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3};
        logic wr;
        logic rd;
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                wr = 1'b0;
                rd = 1'b0;
            end
            runAccess(wr, rd, codes[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                      $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_misalign();
        test_timeout();
        test_reset_midtransfer();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
